// File: rtl/jtcps1_vram_arb.sv
// jtcps1_vram_arb
// ---------------------------------------------------------------------------
// Shares one VRAM/SDRAM read port among three video DMA requesters:
// palette copy (pal), object table copy (obj) and row-scroll fetch (scr).
// The bus is borrowed from the main CPU with busreq/busack, and it is held
// for IDLE_REL idle cycles after the last request so that back-to-back
// requesters can skip a new handshake.
//
// Fixed priority pal > obj > scr applies only when a grant is chosen. Once a
// requester is granted, it keeps the port until its cs falls.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   {pal,obj,scr}_cs/_addr       requester strobe (held to last word) + addr
//   {pal,obj,scr}_ok             combinational data-valid per requester
//   vram_addr, vram_cs, vram_ok  read port toward VRAM/SDRAM
//   busreq, busack               CPU bus sharing handshake
// ---------------------------------------------------------------------------
module jtcps1_vram_arb #(
  parameter int IDLE_REL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pal_cs,
  input  logic        obj_cs,
  input  logic        scr_cs,
  input  logic [17:1] pal_addr,
  input  logic [17:1] obj_addr,
  input  logic [17:1] scr_addr,
  output logic        pal_ok,
  output logic        obj_ok,
  output logic        scr_ok,
  output logic [17:1] vram_addr,
  output logic        vram_cs,
  input  logic        vram_ok,
  output logic        busreq,
  input  logic        busack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ACK,
    S_GRANT,
    S_SWITCH,
    S_HOLD
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_PAL,
    G_OBJ,
    G_SCR
  } gnt_t;

  // Counter holds values 0..IDLE_REL-1; sized for IDLE_REL itself to keep
  // saturation headroom.
  localparam int CW = (IDLE_REL < 2) ? 1 : $clog2(IDLE_REL + 1);
  localparam logic [CW-1:0] REL_LAST = CW'(IDLE_REL - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t         state_q, state_d;
  gnt_t           grant_q, grant_d;
  logic           busreq_q, busreq_d;
  logic           vcs_q, vcs_d;
  logic [17:1]    vaddr_q, vaddr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           any_cs;
  logic           gnt_cs;
  logic [17:1]    gnt_addr;
  gnt_t           pick_gnt;
  logic [17:1]    pick_addr;

  assign any_cs = pal_cs | obj_cs | scr_cs;

  // Strobe/address of the currently latched grant.
  always_comb begin
    gnt_cs   = 1'b0;
    gnt_addr = '0;
    case (grant_q)
      G_PAL:   begin gnt_cs = pal_cs; gnt_addr = pal_addr; end
      G_OBJ:   begin gnt_cs = obj_cs; gnt_addr = obj_addr; end
      G_SCR:   begin gnt_cs = scr_cs; gnt_addr = scr_addr; end
      default: begin gnt_cs = 1'b0;   gnt_addr = '0;       end
    endcase
  end

  // Fixed-priority pick, used only where a fresh grant is chosen.
  always_comb begin
    pick_gnt  = G_NONE;
    pick_addr = '0;
    if (pal_cs) begin
      pick_gnt  = G_PAL;
      pick_addr = pal_addr;
    end else if (obj_cs) begin
      pick_gnt  = G_OBJ;
      pick_addr = obj_addr;
    end else if (scr_cs) begin
      pick_gnt  = G_SCR;
      pick_addr = scr_addr;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    busreq_d = busreq_q;
    vcs_d    = vcs_q;
    vaddr_d  = vaddr_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        vcs_d = 1'b0;
        if (any_cs) begin
          busreq_d = 1'b1;
          state_d  = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        vcs_d = 1'b0;
        if (!any_cs) begin
          grant_d = G_NONE;
          cnt_d   = '0;
          state_d = S_HOLD;
        end else if (busack) begin
          // A grant retained across a busack drop resumes first, so a
          // requester interrupted mid-burst is not overtaken.
          if (grant_q != G_NONE && gnt_cs) begin
            vaddr_d = gnt_addr;
          end else begin
            grant_d = pick_gnt;
            vaddr_d = pick_addr;
          end
          vcs_d   = 1'b1;
          state_d = S_GRANT;
        end
      end

      S_GRANT: begin
        if (!busack) begin
          // CPU took the bus back: stop reading, keep the grant.
          vcs_d   = 1'b0;
          state_d = S_WAIT_ACK;
        end else if (gnt_cs) begin
          vcs_d   = 1'b1;
          vaddr_d = gnt_addr;
        end else begin
          vcs_d   = 1'b0;
          grant_d = G_NONE;
          if (any_cs) begin
            state_d = S_SWITCH;
          end else begin
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end
      end

      // Single dead cycle between two grants; the priority decision is
      // made here so that a cs rising together with the old cs falling is
      // arbitrated fairly.
      S_SWITCH: begin
        vcs_d = 1'b0;
        if (any_cs) begin
          grant_d = pick_gnt;
          vaddr_d = pick_addr;
          vcs_d   = 1'b1;
          state_d = S_GRANT;
        end else begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        vcs_d = 1'b0;
        if (any_cs) begin
          grant_d = pick_gnt;
          vaddr_d = pick_addr;
          vcs_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_GRANT;
        end else if (cnt_q >= REL_LAST) begin
          busreq_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        grant_d  = G_NONE;
        busreq_d = 1'b0;
        vcs_d    = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= G_NONE;
      busreq_q <= 1'b0;
      vcs_q    <= 1'b0;
      vaddr_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      busreq_q <= busreq_d;
      vcs_q    <= vcs_d;
      vaddr_q  <= vaddr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busreq    = busreq_q;
  assign vram_cs   = vcs_q;
  assign vram_addr = vaddr_q;

  // vram_data is shared; only the strobe is steered. Gating with vram_cs
  // drops any late vram_ok after a grant ends or reset hits.
  assign pal_ok = vram_ok & vcs_q & (grant_q == G_PAL);
  assign obj_ok = vram_ok & vcs_q & (grant_q == G_OBJ);
  assign scr_ok = vram_ok & vcs_q & (grant_q == G_SCR);

endmodule

// File: tb/tb_jtcps1_vram_arb.sv
// Directed bench for jtcps1_vram_arb (IDLE_REL = 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_jtcps1_vram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        pal_cs, obj_cs, scr_cs;
  logic [17:1] pal_addr, obj_addr, scr_addr;
  logic        pal_ok, obj_ok, scr_ok;
  logic [17:1] vram_addr;
  logic        vram_cs;
  logic        vram_ok;
  logic        busreq;
  logic        busack;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtcps1_vram_arb #(.IDLE_REL(4)) dut (
    .clk(clk), .rst(rst),
    .pal_cs(pal_cs), .obj_cs(obj_cs), .scr_cs(scr_cs),
    .pal_addr(pal_addr), .obj_addr(obj_addr), .scr_addr(scr_addr),
    .pal_ok(pal_ok), .obj_ok(obj_ok), .scr_ok(scr_ok),
    .vram_addr(vram_addr), .vram_cs(vram_cs), .vram_ok(vram_ok),
    .busreq(busreq), .busack(busack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let HOLD expire (4 idle edges) and return the bus, then one more edge.
  task automatic drain();
    repeat (4) step();
    checks++;
    if (busreq !== 1'b0) begin
      errors++;
      $display("FAIL drain_busreq got %b exp 0", busreq);
    end
    busack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pal_cs = 0; obj_cs = 0; scr_cs = 0;
    pal_addr = '0; obj_addr = '0; scr_addr = '0;
    busack = 0; vram_ok = 1'b1;
    #1;
    checks++;
    if ({busreq, vram_cs, vram_addr, pal_ok, obj_ok, scr_ok} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b/%b/%h/%b%b%b exp all 0",
               busreq, vram_cs, vram_addr, pal_ok, obj_ok, scr_ok);
    end
    vram_ok = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    pal_cs = 1; pal_addr = 17'h0800;
    step();
    checks++;
    if ({busreq, vram_cs} !== 2'b10) begin
      errors++;
      $display("FAIL basic_busreq got %b%b exp 10", busreq, vram_cs);
    end
    step(); step();
    checks++;
    if ({busreq, vram_cs} !== 2'b10) begin
      errors++;
      $display("FAIL basic_wait got %b%b exp 10", busreq, vram_cs);
    end
    busack = 1;
    step();
    checks++;
    if ({vram_cs, vram_addr} !== {1'b1, 17'h0800}) begin
      errors++;
      $display("FAIL basic_grant got %b/%h exp 1/0800", vram_cs, vram_addr);
    end
    vram_ok = 1; #1;
    checks++;
    if ({pal_ok, obj_ok, scr_ok} !== 3'b100) begin
      errors++;
      $display("FAIL basic_ok got %b%b%b exp 100", pal_ok, obj_ok, scr_ok);
    end
    vram_ok = 0; pal_cs = 0;
    step(); // HOLD entry
    step(); step(); step();
    checks++;
    if ({busreq, vram_cs} !== 2'b10) begin
      errors++;
      $display("FAIL basic_hold3 got %b%b exp 10", busreq, vram_cs);
    end
    step();
    checks++;
    if (busreq !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got %b exp 0", busreq);
    end
    busack = 0;
    step();
  endtask

  task automatic test_lock();
    obj_cs = 1; obj_addr = 17'h0100;
    step();
    busack = 1;
    step();
    checks++;
    if ({vram_cs, vram_addr} !== {1'b1, 17'h0100}) begin
      errors++;
      $display("FAIL lock_obj_grant got %b/%h exp 1/0100", vram_cs, vram_addr);
    end
    pal_cs = 1; pal_addr = 17'h0200; obj_addr = 17'h0101;
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_cs, vram_addr, pal_ok, obj_ok} !== {1'b1, 17'h0101, 2'b01}) begin
      errors++;
      $display("FAIL lock_no_preempt got %b/%h/%b%b exp 1/0101/01",
               vram_cs, vram_addr, pal_ok, obj_ok);
    end
    vram_ok = 0; obj_cs = 0;
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_cs, pal_ok, obj_ok, scr_ok} !== 4'b0000) begin
      errors++;
      $display("FAIL lock_dead_cycle got %b/%b%b%b exp 0/000",
               vram_cs, pal_ok, obj_ok, scr_ok);
    end
    vram_ok = 0;
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_cs, vram_addr, pal_ok, obj_ok} !== {1'b1, 17'h0200, 2'b10}) begin
      errors++;
      $display("FAIL lock_pal_after got %b/%h/%b%b exp 1/0200/10",
               vram_cs, vram_addr, pal_ok, obj_ok);
    end
    vram_ok = 0; pal_cs = 0;
    step();
    drain();
  endtask

  task automatic test_simul_and_regrant();
    pal_cs = 1; scr_cs = 1; pal_addr = 17'h0300; scr_addr = 17'h0400;
    step();
    busack = 1;
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_addr, pal_ok, scr_ok} !== {17'h0300, 2'b10}) begin
      errors++;
      $display("FAIL simul_pal_first got %h/%b%b exp 0300/10", vram_addr, pal_ok, scr_ok);
    end
    vram_ok = 0; pal_cs = 0;
    step();
    checks++;
    if (vram_cs !== 1'b0) begin
      errors++;
      $display("FAIL simul_switch got %b exp 0", vram_cs);
    end
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_cs, vram_addr, pal_ok, scr_ok} !== {1'b1, 17'h0400, 2'b01}) begin
      errors++;
      $display("FAIL simul_scr_next got %b/%h/%b%b exp 1/0400/01",
               vram_cs, vram_addr, pal_ok, scr_ok);
    end
    vram_ok = 0; scr_cs = 0;
    step(); // HOLD, count 0
    step(); step(); // count 2
    obj_cs = 1; obj_addr = 17'h0500;
    step();
    checks++;
    if ({busreq, vram_cs, vram_addr} !== {2'b11, 17'h0500}) begin
      errors++;
      $display("FAIL regrant_hold got %b%b/%h exp 11/0500", busreq, vram_cs, vram_addr);
    end
    obj_cs = 0;
    step(); // HOLD with cleared counter
    step(); step(); step();
    checks++;
    if (busreq !== 1'b1) begin
      errors++;
      $display("FAIL regrant_counter_clear got %b exp 1", busreq);
    end
    step();
    checks++;
    if (busreq !== 1'b0) begin
      errors++;
      $display("FAIL regrant_release got %b exp 0", busreq);
    end
    busack = 0;
    step();
  endtask

  task automatic test_busack_drop();
    scr_cs = 1; scr_addr = 17'h1234;
    step();
    busack = 1;
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_cs, vram_addr, scr_ok} !== {1'b1, 17'h1234, 1'b1}) begin
      errors++;
      $display("FAIL ack_scr_grant got %b/%h/%b exp 1/1234/1", vram_cs, vram_addr, scr_ok);
    end
    vram_ok = 0; busack = 0;
    step();
    obj_cs = 1; obj_addr = 17'h0600;
    vram_ok = 1; #1;
    checks++;
    if ({busreq, vram_cs, scr_ok, obj_ok} !== 4'b1000) begin
      errors++;
      $display("FAIL ack_drop got %b%b/%b%b exp 10/00", busreq, vram_cs, scr_ok, obj_ok);
    end
    vram_ok = 0;
    step();
    busack = 1;
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_cs, vram_addr, scr_ok, obj_ok} !== {1'b1, 17'h1234, 2'b10}) begin
      errors++;
      $display("FAIL ack_resume got %b/%h/%b%b exp 1/1234/10",
               vram_cs, vram_addr, scr_ok, obj_ok);
    end
    vram_ok = 0; scr_cs = 0;
    step();
    step();
    checks++;
    if ({vram_cs, vram_addr} !== {1'b1, 17'h0600}) begin
      errors++;
      $display("FAIL ack_obj_after got %b/%h exp 1/0600", vram_cs, vram_addr);
    end
    obj_cs = 0;
    step();
    drain();
  endtask

  task automatic test_reset_mid();
    pal_cs = 1; pal_addr = 17'h0700;
    step();
    busack = 1;
    step();
    vram_ok = 1; #1;
    checks++;
    if (pal_ok !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got %b exp 1", pal_ok);
    end
    rst = 1; #1;
    checks++;
    if ({busreq, vram_cs, vram_addr, pal_ok, obj_ok, scr_ok} !== 22'd0) begin
      errors++;
      $display("FAIL rstmid_abort got %b/%b/%h/%b%b%b exp all 0",
               busreq, vram_cs, vram_addr, pal_ok, obj_ok, scr_ok);
    end
    vram_ok = 0; busack = 0;
    step();
    rst = 0;
    step();
    checks++;
    if ({busreq, vram_cs} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_busreq got %b%b exp 10", busreq, vram_cs);
    end
    busack = 1;
    step();
    vram_ok = 1; #1;
    checks++;
    if ({vram_cs, vram_addr, pal_ok, obj_ok, scr_ok} !== {1'b1, 17'h0700, 3'b100}) begin
      errors++;
      $display("FAIL rstmid_restart got %b/%h/%b%b%b exp 1/0700/100",
               vram_cs, vram_addr, pal_ok, obj_ok, scr_ok);
    end
    vram_ok = 0; pal_cs = 0;
    step();
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lock();
    test_simul_and_regrant();
    test_busack_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtcps1_vram_arb.md
JTCPS1_VRAM_ARB -- requirements
Module: jtcps1_vram_arb

Interface
REQ-001 SHALL have parameter IDLE_REL, default 4: idle cycles with no request before the CPU bus is returned.
REQ-002 SHALL have clk, input, 1: single system clock; all logic clocked on its rising edge.
REQ-003 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have pal_cs / obj_cs / scr_cs, input, 1 each: requester strobes (palette copy, object table copy, row-scroll fetch); each held high until its final word is accepted.
REQ-005 SHALL have pal_addr / obj_addr / scr_addr, input, [17:1] each: requester word addresses.
REQ-006 SHALL have pal_ok / obj_ok / scr_ok, output, 1 each: data valid for that requester; vram_data is shared and not re-registered.
REQ-007 SHALL have vram_addr, output, [17:1]; vram_cs, output, 1; vram_ok, input, 1: VRAM/SDRAM read port.
REQ-008 SHALL have busreq, output, 1; busack, input, 1: main-CPU bus sharing handshake.

Function
REQ-009 SHALL implement states IDLE, WAIT_ACK, GRANT, SWITCH, HOLD.
REQ-010 IDLE: any cs high -> busreq<=1, next WAIT_ACK.
REQ-011 WAIT_ACK: on busack=1, latch grant to the highest-priority active cs (pal > obj > scr) and go to GRANT; if all cs are low, go to HOLD.
REQ-012 GRANT: vram_cs SHALL be 1 from the first GRANT cycle; vram_addr SHALL be registered from the granted requester's addr every cycle (1-cycle latency).
REQ-013 x_ok SHALL equal vram_ok & vram_cs & (grant==x), combinational; non-granted ok outputs SHALL be 0.
REQ-014 Grant SHALL be locked: no pre-emption while the granted cs stays high, even by a higher-priority request.
REQ-015 Granted cs falling: vram_cs<=0; if another cs is high -> SWITCH, else HOLD with idle counter cleared.
REQ-016 SWITCH: one dead cycle (vram_cs=0), then grant the highest-priority active cs and go to GRANT; if none remains active, go to HOLD.
REQ-017 HOLD: busreq stays 1; any cs high -> grant by priority, go to GRANT, counter cleared; otherwise increment counter; when counter reaches IDLE_REL-1 -> busreq<=0, go to IDLE.
REQ-018 The idle counter SHALL be wide enough for IDLE_REL, SHALL saturate and never wrap.
REQ-019 busack falling while in GRANT: vram_cs<=0 in the next cycle, grant retained, go to WAIT_ACK; resume the same requester on busack.
REQ-020 busreq SHALL only change in IDLE->WAIT_ACK (rise) and HOLD->IDLE (fall).
REQ-021 vram_ok arriving while vram_cs=0 SHALL be ignored; no ok is raised.
REQ-022 Simultaneous cs rise with a granted-cs fall SHALL be resolved in SWITCH by priority.

Reset
REQ-023 While rst=1: state IDLE, busreq=0, vram_cs=0, vram_addr=0, grant=none, counter=0, all x_ok=0.
REQ-024 Reset asserted mid-transfer SHALL abort immediately with no ok pulse; after release, operation restarts from IDLE.

Verification
REQ-025 pal_cs=1, pal_addr=0x0800, busack after 3 cycles -> busreq=1 at cycle 1; vram_cs=1 with vram_addr=0x0800 one cycle after busack; vram_ok -> pal_ok=1, obj_ok=scr_ok=0.
REQ-026 obj granted, pal_cs rises mid-burst -> obj keeps the grant until obj_cs falls; 1 dead cycle; then pal granted.
REQ-027 pal_cs and scr_cs both rise in the same cycle in IDLE -> pal served first; scr granted after the SWITCH cycle.
REQ-028 Last cs falls, no new request -> busreq drops exactly IDLE_REL cycles later (4 with default); a request at idle cycle 2 keeps busreq=1 and re-grants with no new handshake.
REQ-029 busack drops during scr burst with addr 0x1234 -> vram_cs=0 next cycle; busack returns -> scr resumes at 0x1234 with no ok lost or duplicated.
REQ-030 rst pulse during active GRANT with vram_ok=1 -> all outputs 0 immediately; after release and pal_cs=1 -> normal REQ-025 sequence.
